// File: rtl/noc_pio_pkg.sv
// noc_pio_pkg
// Shared definitions for the NOC tile PIO:
//   - register word addresses on the Avalon-MM slave
//   - edge detector type encodings (EDGE_TYPE parameter values)
//   - pulse timer FSM state type
package noc_pio_pkg;

    localparam logic [2:0] ADDR_OUT_DATA     = 3'd0;
    localparam logic [2:0] ADDR_IN_DATA      = 3'd1;
    localparam logic [2:0] ADDR_IRQ_MASK     = 3'd2;
    localparam logic [2:0] ADDR_EDGE_CAPTURE = 3'd3;
    localparam logic [2:0] ADDR_OUTSET       = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR     = 3'd5;
    localparam logic [2:0] ADDR_PULSE_MASK   = 3'd6;
    localparam logic [2:0] ADDR_PULSE_LEN    = 3'd7;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PULSING = 1'b1
    } pulse_state_e;

endpackage

// File: rtl/noc_pio_edge_sync.sv
// noc_pio_edge_sync
// Brings the asynchronous input pins into the clk domain and flags edges.
//   clk, reset : system clock, synchronous active-high reset
//   in_port    : asynchronous external inputs
//   sync_data  : synchronised input value (output of the last sync stage)
//   edge_vec   : one-cycle per-bit edge flags, type selected by EDGE_TYPE
// Edge flags are held off for SYNC_STAGES+1 cycles after reset so that
// inputs which were already asserted while in reset do not look like edges
// as the cleared synchroniser fills up.
module noc_pio_edge_sync
    import noc_pio_pkg::*;
#(
    parameter int WIDTH       = 10,
    parameter int EDGE_TYPE   = EDGE_RISING,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] sync_data,
    output logic [WIDTH-1:0] edge_vec
);

    localparam int BLANK = SYNC_STAGES + 1;
    localparam int BW    = $clog2(BLANK + 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_reg;
    logic [WIDTH-1:0]                  prev_reg;
    logic [BW-1:0]                     blank_cnt_reg;
    logic [WIDTH-1:0]                  edge_raw;
    logic                              blank_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_reg      <= '0;
            prev_reg      <= '0;
            blank_cnt_reg <= '0;
        end else begin
            sync_reg[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_reg[i] <= sync_reg[i-1];
            end
            prev_reg <= sync_reg[SYNC_STAGES-1];
            if (blank_cnt_reg != BW'(BLANK)) begin
                blank_cnt_reg <= blank_cnt_reg + BW'(1);
            end
        end
    end

    assign sync_data  = sync_reg[SYNC_STAGES-1];
    assign blank_done = (blank_cnt_reg == BW'(BLANK));

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_edge
            if (EDGE_TYPE == EDGE_FALLING) begin : g_fall
                assign edge_raw[gi] = ~sync_data[gi] & prev_reg[gi];
            end else if (EDGE_TYPE == EDGE_ANY) begin : g_any
                assign edge_raw[gi] = sync_data[gi] ^ prev_reg[gi];
            end else begin : g_rise
                assign edge_raw[gi] = sync_data[gi] & ~prev_reg[gi];
            end
        end
    endgenerate

    assign edge_vec = blank_done ? edge_raw : '0;

endmodule

// File: rtl/noc_pio_ext.sv
// noc_pio_ext
// Avalon-MM slave PIO: output register with atomic set/clear, synchronised
// input with edge capture and maskable IRQ, and a one-shot pulse timer that
// raises selected output bits for PULSE_LEN cycles (minimum 1).
//   clk, reset          : system clock, synchronous active-high reset
//   address, chipselect,
//   write_n, writedata  : Avalon-MM write port (write = chipselect & ~write_n)
//   readdata            : zero-latency read mux on address
//   in_port             : asynchronous inputs
//   out_port            : output register
//   irq                 : |(edge_capture & irq_mask)
module noc_pio_ext
    import noc_pio_pkg::*;
#(
    parameter int          WIDTH       = 10,
    parameter logic [31:0] RESET_VALUE = 32'd0,
    parameter int          EDGE_TYPE   = EDGE_RISING,
    parameter int          SYNC_STAGES = 2,
    parameter int          PULSE_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic             irq
);

    logic [WIDTH-1:0]   out_data_reg, out_data_next;
    logic [WIDTH-1:0]   irq_mask_reg;
    logic [WIDTH-1:0]   edge_capture_reg;
    logic [PULSE_W-1:0] pulse_len_reg;
    logic [WIDTH-1:0]   active_reg;
    logic [PULSE_W-1:0] count_reg;
    pulse_state_e       state_reg;

    logic               wr;
    logic [WIDTH-1:0]   wd;
    logic [WIDTH-1:0]   trig_mask;
    logic               trig;
    logic               pulse_end;
    logic [PULSE_W-1:0] len_eff;
    logic [WIDTH-1:0]   sync_data;
    logic [WIDTH-1:0]   edge_vec;
    logic [WIDTH-1:0]   capture_clear;

    // Upper writedata bits are deliberately ignored.
    logic unused_wd;
    assign unused_wd = ^writedata;

    noc_pio_edge_sync #(
        .WIDTH      (WIDTH),
        .EDGE_TYPE  (EDGE_TYPE),
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge_sync (
        .clk      (clk),
        .reset    (reset),
        .in_port  (in_port),
        .sync_data(sync_data),
        .edge_vec (edge_vec)
    );

    assign wr        = chipselect & ~write_n;
    assign wd        = writedata[WIDTH-1:0];
    assign trig_mask = (wr && address == ADDR_PULSE_MASK) ? wd : '0;
    assign trig      = |trig_mask;
    assign len_eff   = (pulse_len_reg == '0) ? PULSE_W'(1) : pulse_len_reg;

    // A retrigger on the final count reloads the timer rather than ending it.
    assign pulse_end = (state_reg == ST_PULSING) && (count_reg == PULSE_W'(1)) && !trig;

    assign capture_clear = (wr && address == ADDR_EDGE_CAPTURE) ? wd : '0;

    // Pulse effects first, CPU write last so it owns any bit it touches.
    always_comb begin
        out_data_next = out_data_reg;
        if (trig) begin
            out_data_next = out_data_next | trig_mask;
        end
        if (pulse_end) begin
            out_data_next = out_data_next & ~active_reg;
        end
        if (wr) begin
            case (address)
                ADDR_OUT_DATA: out_data_next = wd;
                ADDR_OUTSET:   out_data_next = out_data_next | wd;
                ADDR_OUTCLEAR: out_data_next = out_data_next & ~wd;
                default:       ;
            endcase
        end
    end

    // Pulse timer FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            active_reg <= '0;
            count_reg  <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (trig) begin
                        active_reg <= trig_mask;
                        count_reg  <= len_eff;
                        state_reg  <= ST_PULSING;
                    end
                end
                ST_PULSING: begin
                    if (trig) begin
                        active_reg <= active_reg | trig_mask;
                        count_reg  <= len_eff;
                    end else if (pulse_end) begin
                        active_reg <= '0;
                        count_reg  <= '0;
                        state_reg  <= ST_IDLE;
                    end else begin
                        count_reg <= count_reg - PULSE_W'(1);
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Register file
    always_ff @(posedge clk) begin
        if (reset) begin
            out_data_reg     <= RESET_VALUE[WIDTH-1:0];
            irq_mask_reg     <= '0;
            edge_capture_reg <= '0;
            pulse_len_reg    <= '0;
        end else begin
            out_data_reg <= out_data_next;
            // A new edge on a bit being cleared keeps the bit set.
            edge_capture_reg <= (edge_capture_reg & ~capture_clear) | edge_vec;
            if (wr && address == ADDR_IRQ_MASK) begin
                irq_mask_reg <= wd;
            end
            if (wr && address == ADDR_PULSE_LEN) begin
                pulse_len_reg <= writedata[PULSE_W-1:0];
            end
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_OUT_DATA:     readdata[WIDTH-1:0]   = out_data_reg;
            ADDR_IN_DATA:      readdata[WIDTH-1:0]   = sync_data;
            ADDR_IRQ_MASK:     readdata[WIDTH-1:0]   = irq_mask_reg;
            ADDR_EDGE_CAPTURE: readdata[WIDTH-1:0]   = edge_capture_reg;
            ADDR_PULSE_MASK:   readdata[WIDTH-1:0]   = active_reg;
            ADDR_PULSE_LEN:    readdata[PULSE_W-1:0] = pulse_len_reg;
            default:           readdata              = '0;
        endcase
    end

    assign out_port = out_data_reg;
    assign irq      = |(edge_capture_reg & irq_mask_reg);

endmodule

// File: tb/tb_noc_pio_ext.sv
module tb_noc_pio_ext;

    localparam int        S  = 2;
    localparam logic [9:0] RV = 10'h155;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [9:0]  in_port;
    logic [9:0]  out_port;
    logic        irq;

    always #5 clk = ~clk;

    noc_pio_ext #(
        .WIDTH      (10),
        .RESET_VALUE(32'h155),
        .EDGE_TYPE  (0),
        .SYNC_STAGES(S),
        .PULSE_W    (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .in_port   (in_port),
        .out_port  (out_port),
        .irq       (irq)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic check_rd(input string name, input logic [2:0] a, input logic [31:0] exp);
        address = a;
        #1;
        check(name, readdata, exp);
    endtask

    task automatic count_high(input logic [9:0] bits, output int n);
        n = 0;
        while ((out_port & bits) != 10'h0 && n < 40) begin
            n++;
            tick();
        end
    endtask

    // ---------------- reference model ----------------
    logic [9:0]  m_out, m_mask, m_cap, m_active;
    logic [15:0] m_len;
    int          m_rem;
    int          m_cyc;
    logic [9:0]  m_q[$];   // in_port samples, newest first

    task automatic model_reset;
        m_out = RV; m_mask = '0; m_cap = '0; m_active = '0;
        m_len = '0; m_rem = 0; m_cyc = 0;
        m_q.delete();
        for (int i = 0; i <= S; i++) m_q.push_front(10'h0);
    endtask

    task automatic model_step(input bit w, input logic [2:0] a, input logic [31:0] d,
                              input logic [9:0] inp);
        logic [9:0] wv, e, trig;
        wv   = d[9:0];
        e    = (m_cyc >= S + 1) ? (m_q[S-1] & ~m_q[S]) : 10'h0;
        m_cap = (m_cap & ~((w && a == 3'd3) ? wv : 10'h0)) | e;
        trig = (w && a == 3'd6) ? wv : 10'h0;
        if (trig != 0) begin
            m_out    = m_out | trig;
            m_active = m_active | trig;
            m_rem    = (m_len == 0) ? 1 : int'(m_len);
        end else if (m_active != 0) begin
            m_rem--;
            if (m_rem == 0) begin
                m_out    = m_out & ~m_active;
                m_active = '0;
            end
        end
        if (w) begin
            case (a)
                3'd0: m_out  = wv;
                3'd2: m_mask = wv;
                3'd4: m_out  = m_out | wv;
                3'd5: m_out  = m_out & ~wv;
                3'd7: m_len  = d[15:0];
                default: ;
            endcase
        end
        m_q.push_front(inp);
        void'(m_q.pop_back());
        if (m_cyc < 1000) m_cyc++;
    endtask

    function automatic logic [31:0] model_rd(input logic [2:0] a);
        case (a)
            3'd0: return {22'h0, m_out};
            3'd1: return {22'h0, m_q[S-1]};
            3'd2: return {22'h0, m_mask};
            3'd3: return {22'h0, m_cap};
            3'd6: return {22'h0, m_active};
            3'd7: return {16'h0, m_len};
            default: return 32'h0;
        endcase
    endfunction

    // ---------------- directed vectors ----------------
    typedef struct {
        bit          wr;
        logic [2:0]  addr;
        logic [31:0] wd;
        logic [2:0]  rd_addr;
        logic [31:0] exp_rd;
        logic [9:0]  exp_out;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        logic [31:0] v;

        vecs[0] = '{0, 3'd0, 32'h0,         3'd0, 32'h155, 10'h155};
        vecs[1] = '{1, 3'd0, 32'hFFFF_F3A5, 3'd0, 32'h3A5, 10'h3A5};
        vecs[2] = '{1, 3'd0, 32'h0F0,       3'd0, 32'h0F0, 10'h0F0};
        vecs[3] = '{1, 3'd4, 32'h00F,       3'd4, 32'h0,   10'h0FF};
        vecs[4] = '{1, 3'd5, 32'h030,       3'd5, 32'h0,   10'h0CF};
        vecs[5] = '{1, 3'd2, 32'h001,       3'd2, 32'h001, 10'h0CF};
        vecs[6] = '{1, 3'd7, 32'h0001_0005, 3'd7, 32'h005, 10'h0CF};
        vecs[7] = '{1, 3'd1, 32'h3FF,       3'd1, 32'h0,   10'h0CF};

        reset = 1'b1; chipselect = 1'b0; write_n = 1'b1;
        address = 3'd0; writedata = 32'h0; in_port = 10'h0;
        tick(); tick();
        reset = 1'b0;
        check("reset_irq", {31'h0, irq}, 32'h0);

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].wr) do_write(vecs[i].addr, vecs[i].wd);
            check_rd($sformatf("vec%0d_rd", i), vecs[i].rd_addr, vecs[i].exp_rd);
            check($sformatf("vec%0d_out", i), {22'h0, out_port}, {22'h0, vecs[i].exp_out});
        end

        // Edge capture / irq (mask = 0x001 from the table)
        in_port = 10'h001;
        tick();
        check_rd("in_data_1cyc", 3'd1, 32'h0);
        tick();
        check_rd("in_data_2cyc", 3'd1, 32'h1);
        check_rd("cap_early", 3'd3, 32'h0);
        check("irq_early", {31'h0, irq}, 32'h0);
        tick();
        check_rd("cap_bit0", 3'd3, 32'h1);
        check("irq_bit0", {31'h0, irq}, 32'h1);
        in_port = 10'h003;
        tick(); tick(); tick();
        check_rd("cap_bit1", 3'd3, 32'h3);
        check("irq_bit1", {31'h0, irq}, 32'h1);
        do_write(3'd3, 32'h1);
        check_rd("cap_clr", 3'd3, 32'h2);
        check("irq_clr", {31'h0, irq}, 32'h0);
        in_port = 10'h002;
        tick(); tick(); tick(); tick();
        check_rd("cap_fall", 3'd3, 32'h2);
        in_port = 10'h003;
        tick(); tick();
        do_write(3'd3, 32'h1);   // clear lands on the capture edge
        check_rd("cap_set_wins", 3'd3, 32'h3);
        check("irq_set_wins", {31'h0, irq}, 32'h1);
        do_write(3'd3, 32'h3FF);
        in_port = 10'h0;

        // Pulse timer
        do_write(3'd7, 32'd5);
        do_write(3'd6, 32'h200);
        count_high(10'h200, n);
        check("pulse_len5", n, 32'd5);
        do_write(3'd7, 32'd0);
        do_write(3'd6, 32'h200);
        count_high(10'h200, n);
        check("pulse_len0", n, 32'd1);
        do_write(3'd7, 32'd5);
        do_write(3'd6, 32'h0);
        check("pulse_zero_trig", {22'h0, out_port}, 32'h0CF);
        do_write(3'd6, 32'h200);
        tick(); tick();
        do_write(3'd6, 32'h100);
        check_rd("retrig_active", 3'd6, 32'h300);
        count_high(10'h300, n);
        check("retrig_len", n, 32'd5);
        check_rd("retrig_idle", 3'd6, 32'h0);

        do_write(3'd7, 32'd3);
        do_write(3'd6, 32'h200);
        tick(); tick();
        do_write(3'd0, 32'h200);   // lands on the pulse-end edge
        check("end_cpu_wins", {22'h0, out_port}, 32'h200);
        check_rd("end_active", 3'd6, 32'h0);

        do_write(3'd7, 32'd5);
        do_write(3'd6, 32'h001);
        tick();
        reset = 1'b1; tick(); reset = 1'b0;
        check("midpulse_out", {22'h0, out_port}, {22'h0, RV});
        check_rd("midpulse_active", 3'd6, 32'h0);
        check_rd("midpulse_len", 3'd7, 32'h0);
        tick(); tick(); tick();
        check("midpulse_after", {22'h0, out_port}, {22'h0, RV});

        // Inputs high through reset produce no edges
        in_port = 10'h3FF;
        reset = 1'b1; tick(); reset = 1'b0;
        tick();
        check_rd("blank_in_1", 3'd1, 32'h0);
        tick();
        check_rd("blank_in_2", 3'd1, 32'h3FF);
        tick(); tick(); tick(); tick();
        do_write(3'd2, 32'h3FF);
        check_rd("blank_cap", 3'd3, 32'h0);
        check("blank_irq", {31'h0, irq}, 32'h0);

        // Randomised run against the model
        in_port = 10'h0;
        reset = 1'b1; tick(); reset = 1'b0;
        model_reset();
        for (int c = 0; c < 2000; c++) begin
            logic [2:0]  ra, a;
            logic [31:0] d;
            int          kind;
            bit          rst;
            ra = 3'($urandom_range(0, 7));
            check_rd("rand_rd", ra, model_rd(ra));
            check("rand_out", {22'h0, out_port}, {22'h0, m_out});
            check("rand_irq", {31'h0, irq}, {31'h0, |(m_cap & m_mask)});

            rst  = ($urandom_range(0, 199) == 0);
            kind = $urandom_range(0, 5);
            a    = 3'($urandom_range(0, 7));
            d    = $urandom;
            if (a == 3'd7) d = (d & 32'hFFFF_0000) | 32'($urandom_range(0, 6));
            if (a == 3'd6 && $urandom_range(0, 3) == 0) d = d & 32'hFFFF_FC00;
            address    = a;
            writedata  = d;
            chipselect = (kind != 2 && kind != 3);
            write_n    = (kind >= 3);
            if ($urandom_range(0, 3) == 0) in_port = 10'($urandom);
            reset = rst;
            if (rst) model_reset();
            else     model_step(chipselect & ~write_n, a, d, in_port);
            tick();
            reset = 1'b0;
        end
        chipselect = 1'b0;
        write_n    = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
